// File: rtl/i2s_sample_feeder.sv
// I2S sample feeder: FIFO-buffers 16-bit PCM samples and presents one
// stable sample per LRCK slot to the I2S serializer (AUD_XCK domain).
//
// Ports:
//   AUD_XCK        codec master clock, the only clock
//   reset          asynchronous reset, active-high
//   sample_in      PCM sample from the producer
//   sample_valid   producer offers sample_in
//   sample_ready   FIFO can accept (push = valid & ready)
//   enable         0: no pops, slots output zero, FIFO kept
//   flush          synchronous FIFO clear
//   AUD_LRCK       LRCK from the transmitter (0 = left)
//   audiodata      sample for the current slot
//   slot_right     audiodata belongs to the right slot
//   fill_level     samples held, 0..DEPTH
//   underrun_count saturating count of pops while empty
module i2s_sample_feeder #(
    parameter int DEPTH         = 16,
    parameter int AW            = 4,
    parameter bit MONO          = 1'b0,
    parameter bit UNDERRUN_HOLD = 1'b0
) (
    input  logic          AUD_XCK,
    input  logic          reset,
    input  logic [15:0]   sample_in,
    input  logic          sample_valid,
    output logic          sample_ready,
    input  logic          enable,
    input  logic          flush,
    input  logic          AUD_LRCK,
    output logic [15:0]   audiodata,
    output logic          slot_right,
    output logic [AW:0]   fill_level,
    output logic [15:0]   underrun_count
);

    localparam logic [AW:0]   L_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   L_ONE  = 1;
    localparam logic [AW-1:0] P_ONE  = 1;

    typedef enum logic {S_IDLE, S_LOAD} state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_lrck_q;
    logic          r_rst_done;
    logic [15:0]   r_audio;
    logic          r_slot;
    logic [15:0]   r_ucnt;

    logic          w_edge;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop_slot;
    logic          w_take;
    logic          w_under;
    logic [15:0]   w_audio_nxt;

    assign w_edge  = AUD_LRCK ^ r_lrck_q;
    assign w_full  = (r_count == L_FULL);
    assign w_empty = (r_count == '0);

    // r_rst_done keeps ready low until the first clock after release
    assign sample_ready = r_rst_done & ~reset & ~flush & ~w_full;
    assign w_push       = sample_valid & sample_ready;

    assign audiodata      = r_audio;
    assign slot_right     = r_slot;
    assign fill_level     = r_count;
    assign underrun_count = r_ucnt;

    always_comb begin
        w_state_nxt = S_IDLE;
        w_pop_slot  = 1'b0;
        w_take      = 1'b0;
        w_under     = 1'b0;
        w_audio_nxt = r_audio;

        unique case (r_state)
            S_IDLE:  w_state_nxt = w_edge ? S_LOAD : S_IDLE;
            S_LOAD:  w_state_nxt = w_edge ? S_LOAD : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_edge) begin
            // mono pops only on the falling edge; the right slot repeats
            w_pop_slot = enable & (~MONO | ~AUD_LRCK);
            // an edge during flush sees an empty FIFO
            w_take     = w_pop_slot & ~flush & ~w_empty;
            w_under    = w_pop_slot & (flush | w_empty);
            if (!enable) begin
                w_audio_nxt = '0;
            end else if (w_take) begin
                w_audio_nxt = r_mem[r_rd_ptr];
            end else if (w_under) begin
                w_audio_nxt = UNDERRUN_HOLD ? r_audio : '0;
            end
        end
    end

    always_ff @(posedge AUD_XCK or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_lrck_q   <= 1'b0;
            r_rst_done <= 1'b0;
            r_audio    <= '0;
            r_slot     <= 1'b0;
            r_ucnt     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lrck_q   <= AUD_LRCK;
            r_rst_done <= 1'b1;
            if (w_edge) begin
                r_slot  <= AUD_LRCK;
                r_audio <= w_audio_nxt;
            end
            if (w_under && r_ucnt != 16'hFFFF) begin
                r_ucnt <= r_ucnt + 16'd1;
            end
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + P_ONE;
                if (w_take) r_rd_ptr <= r_rd_ptr + P_ONE;
                unique case ({w_push, w_take})
                    2'b10:   r_count <= r_count + L_ONE;
                    2'b01:   r_count <= r_count - L_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge AUD_XCK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sample_in;
        end
    end

endmodule

// File: tb/tb_i2s_sample_feeder.sv
// Testbench for i2s_sample_feeder: stereo/no-hold and mono/hold
// instances against a queue-based reference model.
module tb_i2s_sample_feeder;

    logic        clk;
    logic        rst;
    logic [15:0] s_in;
    logic        s_valid;
    logic        en;
    logic        fl;
    logic        lrck;

    logic        a_ready, b_ready;
    logic [15:0] a_audio, b_audio;
    logic        a_slot, b_slot;
    logic [4:0]  a_fill, b_fill;
    logic [15:0] a_ucnt, b_ucnt;

    int n_chk;
    int n_err;

    // reference model state: [0] stereo/no-hold, [1] mono/hold
    logic [15:0] mq [2][$];
    logic [15:0] m_out [2];
    logic        m_slot [2];
    int          m_ucnt [2];
    logic        m_lq;
    logic        m_rdy;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        lr;
        logic        e;
        int          idle;
        logic [15:0] exp_a;
        logic [4:0]  exp_fill;
        logic        exp_slot;
    } vec_t;

    vec_t tbl [9];

    i2s_sample_feeder #(
        .DEPTH(16), .AW(4), .MONO(1'b0), .UNDERRUN_HOLD(1'b0)
    ) u_a (
        .AUD_XCK(clk), .reset(rst),
        .sample_in(s_in), .sample_valid(s_valid),
        .sample_ready(a_ready), .enable(en), .flush(fl),
        .AUD_LRCK(lrck), .audiodata(a_audio),
        .slot_right(a_slot), .fill_level(a_fill),
        .underrun_count(a_ucnt)
    );

    i2s_sample_feeder #(
        .DEPTH(16), .AW(4), .MONO(1'b1), .UNDERRUN_HOLD(1'b1)
    ) u_b (
        .AUD_XCK(clk), .reset(rst),
        .sample_in(s_in), .sample_valid(s_valid),
        .sample_ready(b_ready), .enable(en), .flush(fl),
        .AUD_LRCK(lrck), .audiodata(b_audio),
        .slot_right(b_slot), .fill_level(b_fill),
        .underrun_count(b_ucnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic exp_rdy(int c);
        return !rst && m_rdy && !fl && (mq[c].size() != 16);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            mq[c].delete();
            m_out[c]  = '0;
            m_slot[c] = 1'b0;
            m_ucnt[c] = 0;
        end
        m_lq  = 1'b0;
        m_rdy = 1'b0;
    endtask

    // one clock of behaviour, from the inputs present before the edge
    task automatic model_step();
        logic edge_;
        logic mono;
        logic hold;
        logic push;
        edge_ = lrck ^ m_lq;
        for (int c = 0; c < 2; c++) begin
            mono = (c == 1);
            hold = (c == 1);
            push = s_valid && exp_rdy(c);
            if (edge_) begin
                m_slot[c] = lrck;
                if (!en) begin
                    m_out[c] = '0;
                end else if (!mono || !lrck) begin
                    if (!fl && mq[c].size() > 0) begin
                        m_out[c] = mq[c].pop_front();
                    end else begin
                        if (!hold) m_out[c] = '0;
                        if (m_ucnt[c] < 65535) m_ucnt[c]++;
                    end
                end
            end
            if (fl) mq[c].delete();
            else if (push) mq[c].push_back(s_in);
        end
        m_lq  = lrck;
        m_rdy = 1'b1;
    endtask

    task automatic check_all();
        chk("a_audio", 32'(a_audio), 32'(m_out[0]));
        chk("a_slot",  32'(a_slot),  32'(m_slot[0]));
        chk("a_fill",  32'(a_fill),  32'(mq[0].size()));
        chk("a_ucnt",  32'(a_ucnt),  32'(m_ucnt[0]));
        chk("a_ready", 32'(a_ready), 32'(exp_rdy(0)));
        chk("b_audio", 32'(b_audio), 32'(m_out[1]));
        chk("b_slot",  32'(b_slot),  32'(m_slot[1]));
        chk("b_fill",  32'(b_fill),  32'(mq[1].size()));
        chk("b_ucnt",  32'(b_ucnt),  32'(m_ucnt[1]));
        chk("b_ready", 32'(b_ready), 32'(exp_rdy(1)));
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic push(logic [15:0] v);
        s_valid = 1'b1;
        s_in    = v;
        cyc();
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_async_audio", 32'(a_audio), 32'h0);
        chk("rst_async_fill",  32'(a_fill),  32'h0);
        chk("rst_async_ucnt",  32'(b_ucnt),  32'h0);
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        chk("rst_release_ready", 32'(a_ready), 32'h0);
        check_all();
        cyc();
        chk("rst_ready_after", 32'(a_ready), 32'h1);
    endtask

    initial begin
        int p;
        rst = 1'b0; s_in = '0; s_valid = 1'b0;
        en = 1'b0; fl = 1'b0; lrck = 1'b0;
        n_chk = 0; n_err = 0;
        model_reset();

        tbl[0] = '{1'b0, 16'h0000, 1'b1, 1'b0, 2,   16'h0000, 5'd0, 1'b1};
        tbl[1] = '{1'b1, 16'h1111, 1'b1, 1'b1, 0,   16'h0000, 5'd1, 1'b1};
        tbl[2] = '{1'b1, 16'h2222, 1'b1, 1'b1, 0,   16'h0000, 5'd2, 1'b1};
        tbl[3] = '{1'b1, 16'h3333, 1'b1, 1'b1, 0,   16'h0000, 5'd3, 1'b1};
        tbl[4] = '{1'b1, 16'h4444, 1'b1, 1'b1, 0,   16'h0000, 5'd4, 1'b1};
        tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b1, 191, 16'h1111, 5'd3, 1'b0};
        tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b1, 191, 16'h2222, 5'd2, 1'b1};
        tbl[7] = '{1'b0, 16'h0000, 1'b0, 1'b1, 191, 16'h3333, 5'd1, 1'b0};
        tbl[8] = '{1'b0, 16'h0000, 1'b1, 1'b1, 191, 16'h4444, 5'd0, 1'b1};

        #2;
        do_reset();

        // park LRCK high without popping
        lrck = 1'b1;
        idle(3);
        en = 1'b1;

        // underrun on an empty FIFO
        for (int k = 0; k < 3; k++) begin
            lrck = ~lrck;
            cyc();
            idle(3);
        end
        chk("t3_a_audio", 32'(a_audio), 32'h0);
        chk("t3_a_ucnt",  32'(a_ucnt),  32'd3);
        chk("t3_b_ucnt",  32'(b_ucnt),  32'd2);

        // hold-on-underrun keeps the last real sample
        push(16'h7FFF);
        for (int k = 0; k < 4; k++) begin
            lrck = ~lrck;
            cyc();
            idle(3);
        end
        chk("t3_b_hold", 32'(b_audio), 32'h7FFF);
        chk("t3_a_zero", 32'(a_audio), 32'h0);
        chk("t3_b_ucnt2", 32'(b_ucnt), 32'd3);

        // stereo ordering, table driven
        fl = 1'b1; cyc(); fl = 1'b0;
        en = 1'b0; lrck = 1'b0; idle(2);
        for (int i = 0; i < 9; i++) begin
            s_valid = tbl[i].v;
            s_in    = tbl[i].d;
            lrck    = tbl[i].lr;
            en      = tbl[i].e;
            cyc();
            chk($sformatf("t2_audio[%0d]", i), 32'(a_audio),
                32'(tbl[i].exp_a));
            chk($sformatf("t2_fill[%0d]", i), 32'(a_fill),
                32'(tbl[i].exp_fill));
            chk($sformatf("t2_slot[%0d]", i), 32'(a_slot),
                32'(tbl[i].exp_slot));
            s_valid = 1'b0;
            idle(tbl[i].idle);
        end

        // mono: one pop per frame, repeated in both slots
        fl = 1'b1; cyc(); fl = 1'b0;
        push(16'hA5A5);
        push(16'h5A5A);
        lrck = 1'b0; cyc();
        chk("t5_l0", 32'(b_audio), 32'hA5A5);
        chk("t5_f0", 32'(b_fill), 32'd1);
        idle(2);
        lrck = 1'b1; cyc();
        chk("t5_r0", 32'(b_audio), 32'hA5A5);
        chk("t5_s0", 32'(b_slot), 32'd1);
        chk("t5_f1", 32'(b_fill), 32'd1);
        idle(2);
        lrck = 1'b0; cyc();
        chk("t5_l1", 32'(b_audio), 32'h5A5A);
        chk("t5_f2", 32'(b_fill), 32'd0);
        idle(2);
        lrck = 1'b1; cyc();
        chk("t5_r1", 32'(b_audio), 32'h5A5A);
        idle(2);

        // flush with 5 queued
        for (int i = 0; i < 5; i++) push(16'(16'hC000 + i));
        chk("t6_pre_fill", 32'(a_fill), 32'd5);
        fl = 1'b1; cyc(); fl = 1'b0;
        chk("t6_flush_a", 32'(a_fill), 32'd0);
        chk("t6_flush_b", 32'(b_fill), 32'd0);

        // fill to DEPTH, 17th refused, push+pop while full
        for (int i = 0; i < 16; i++) push(16'(16'h0100 + i));
        chk("t4_full", 32'(a_fill), 32'd16);
        chk("t4_ready", 32'(a_ready), 32'd0);
        push(16'hDEAD);
        chk("t4_17th", 32'(a_fill), 32'd16);
        s_valid = 1'b1; s_in = 16'hBEEF;
        lrck = ~lrck;
        cyc();
        chk("t4_pp_15", 32'(a_fill), 32'd15);
        chk("t4_pp_head", 32'(a_audio), 32'h0100);
        cyc();
        s_valid = 1'b0;
        chk("t4_refill", 32'(a_fill), 32'd16);
        idle(2);

        // enable low across two edges
        en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            lrck = ~lrck;
            cyc();
            chk("t6_en_a", 32'(a_audio), 32'h0);
            chk("t6_en_b", 32'(b_audio), 32'h0);
            chk("t6_en_fill", 32'(a_fill), 32'd16);
            idle(3);
        end
        en = 1'b1;
        lrck = ~lrck; cyc(); idle(3);

        // reset in the middle of a stream
        do_reset();

        // randomized traffic in epochs of varying producer rate
        for (int ep = 0; ep < 8; ep++) begin
            p = $urandom_range(0, 4);
            for (int i = 0; i < 500; i++) begin
                s_valid = ($urandom_range(0, 3) < p);
                s_in    = 16'($urandom);
                if ($urandom_range(0, 5) == 0) lrck = ~lrck;
                en = ($urandom_range(0, 15) != 0);
                fl = ($urandom_range(0, 99) == 0);
                cyc();
            end
        end
        s_valid = 1'b0; fl = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
